mem_router_ws: RTL and testbench

- Parametrised successor to the combinational address router at the top level.
- Decodes a CPU byte access into one of NREG base/mask regions, with lowest index winning on overlap.
- Inserts a per-region programmable number of wait states and returns read data through a req/ready handshake.
- Drives open-bus data and a sticky fault flag for unmapped accesses. Sits between core and the m256k/m16k/m8k memory blocks.

---
 rtl/mem_router_ws.sv | 113 +++++++++++
 tb/tb_mem_router_ws.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/mem_router_ws.sv
// Byte-access router: decodes a CPU access into one of NREG base/mask regions,
// inserts per-region wait states and returns read data through a req/ready handshake.
module mem_router_ws #(
    parameter int                  AW       = 20,
    parameter int                  DW       = 8,
    parameter int                  NREG     = 4,
    parameter logic [NREG-1:0]     REG_EN   = 4'b0111,
    parameter logic [NREG*AW-1:0]  REG_BASE = {20'h0, 20'hFE000, 20'hA0000, 20'h00000},
    parameter logic [NREG*AW-1:0]  REG_MASK = {20'h0, 20'hFE000, 20'hFC000, 20'hC0000},
    parameter logic [NREG*4-1:0]   REG_WAIT = {4'd0, 4'd0, 4'd1, 4'd0},
    parameter logic [DW-1:0]       OPEN_BUS = 8'hFF
) (
    input  logic                 clock,
    input  logic                 reset_n,
    input  logic [AW-1:0]        cpu_address,
    input  logic [DW-1:0]        cpu_out,
    input  logic                 cpu_we,
    input  logic                 cpu_req,
    output logic [DW-1:0]        cpu_in,
    output logic                 cpu_ready,
    output logic [AW-1:0]        mem_address,
    output logic [DW-1:0]        mem_d,
    output logic [NREG-1:0]      mem_we,
    input  logic [NREG*DW-1:0]   mem_q,
    output logic                 fault,
    input  logic                 fault_clr
);
    localparam int SW = (NREG > 1) ? $clog2(NREG) : 1;

    typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

    state_t          state;
    logic [AW-1:0]   addr_q;
    logic [DW-1:0]   d_q;
    logic            we_q;
    logic            hit_q;
    logic [SW-1:0]   sel_q;
    logic [3:0]      cnt;

    logic            dec_hit;
    logic [SW-1:0]   dec_sel;
    logic [3:0]      dec_wait;
    logic            access_end;
    logic [DW-1:0]   q_sel;

    // Scan from the top down so the lowest matching index is the one left standing.
    always_comb begin
        dec_hit = 1'b0;
        dec_sel = '0;
        for (int i = NREG - 1; i >= 0; i--) begin
            if (REG_EN[i] && ((cpu_address & REG_MASK[i*AW +: AW]) == REG_BASE[i*AW +: AW])) begin
                dec_hit = 1'b1;
                dec_sel = SW'(i);
            end
        end
        dec_wait = dec_hit ? REG_WAIT[dec_sel*4 +: 4] : 4'd0;
    end

    assign access_end  = (state == ACCESS) && (cnt == 4'd0);
    assign q_sel       = mem_q[sel_q*DW +: DW];
    assign mem_address = addr_q;
    assign mem_d       = d_q;

    always_comb begin
        mem_we = '0;
        if (access_end && we_q && hit_q)
            mem_we[sel_q] = 1'b1;
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state     <= IDLE;
            addr_q    <= '0;
            d_q       <= '0;
            we_q      <= 1'b0;
            hit_q     <= 1'b0;
            sel_q     <= '0;
            cnt       <= 4'd0;
            cpu_in    <= OPEN_BUS;
            cpu_ready <= 1'b0;
            fault     <= 1'b0;
        end else begin
            cpu_ready <= (state == DONE);
            if (access_end && !hit_q)
                fault <= 1'b1;
            else if (fault_clr)
                fault <= 1'b0;
            case (state)
                IDLE: begin
                    if (cpu_req) begin
                        addr_q <= cpu_address;
                        d_q    <= cpu_out;
                        we_q   <= cpu_we;
                        hit_q  <= dec_hit;
                        sel_q  <= dec_sel;
                        cnt    <= dec_wait;
                        state  <= ACCESS;
                    end
                end
                ACCESS: begin
                    if (cnt != 4'd0) begin
                        cnt <= cnt - 4'd1;
                    end else begin
                        cpu_in <= hit_q ? q_sel : OPEN_BUS;
                        state  <= DONE;
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mem_router_ws.sv
// Scoreboard bench for mem_router_ws: drivers push expected ready/strobe events,
// a monitor pops and compares them whenever the DUT presents cpu_ready or mem_we.
module tb_mem_router_ws;
    logic         clock = 1'b0;
    logic         reset_n;
    logic [19:0]  cpu_address;
    logic [7:0]   cpu_out;
    logic         cpu_we;
    logic         cpu_req;
    logic [7:0]   cpu_in;
    logic         cpu_ready;
    logic [19:0]  mem_address;
    logic [7:0]   mem_d;
    logic [3:0]   mem_we;
    logic [31:0]  mem_q;
    logic         fault;
    logic         fault_clr;

    int errors = 0;
    int checks = 0;

    typedef struct packed { logic [7:0] data; logic flt; } rdy_t;
    typedef struct packed { logic [3:0] we; logic [19:0] addr; logic [7:0] d; } stb_t;
    rdy_t rdy_q[$];
    stb_t stb_q[$];

    always #5 clock = ~clock;

    mem_router_ws #(
        .REG_EN  (4'b1111),
        .REG_BASE({20'h00000, 20'hFE000, 20'hA0000, 20'h00000}),
        .REG_MASK({20'hC0000, 20'hFE000, 20'hFC000, 20'hC0000}),
        .REG_WAIT({4'd5, 4'd15, 4'd1, 4'd0})
    ) dut (
        .clock(clock), .reset_n(reset_n), .cpu_address(cpu_address), .cpu_out(cpu_out),
        .cpu_we(cpu_we), .cpu_req(cpu_req), .cpu_in(cpu_in), .cpu_ready(cpu_ready),
        .mem_address(mem_address), .mem_d(mem_d), .mem_we(mem_we), .mem_q(mem_q),
        .fault(fault), .fault_clr(fault_clr)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    always @(negedge clock) begin
        if (cpu_ready) begin
            if (rdy_q.size() == 0) begin
                chk("unexpected_ready", 32'd1, 32'd0);
            end else begin
                rdy_t e;
                e = rdy_q.pop_front();
                chk("cpu_in", {24'd0, cpu_in}, {24'd0, e.data});
                chk("fault_at_ready", {31'd0, fault}, {31'd0, e.flt});
            end
        end
        if (mem_we != 4'b0000) begin
            if (stb_q.size() == 0) begin
                chk("unexpected_mem_we", {28'd0, mem_we}, 32'd0);
            end else begin
                stb_t s;
                s = stb_q.pop_front();
                chk("mem_we", {28'd0, mem_we}, {28'd0, s.we});
                chk("mem_address", {12'd0, mem_address}, {12'd0, s.addr});
                chk("mem_d", {24'd0, mem_d}, {24'd0, s.d});
            end
        end
    end

    task automatic access(input logic [19:0] a, input logic [7:0] d, input logic we,
                          input int lat, input logic [7:0] exp_in, input logic exp_f,
                          input logic [3:0] exp_we, input bit toggle, input bit clr_in_access);
        int  k;
        bit  got;
        rdy_q.push_back('{data: exp_in, flt: exp_f});
        if (exp_we != 4'b0000) stb_q.push_back('{we: exp_we, addr: a, d: d});
        @(negedge clock);
        cpu_address = a; cpu_out = d; cpu_we = we; cpu_req = 1'b1;
        @(posedge clock);
        @(negedge clock);
        cpu_req = 1'b0; cpu_address = ~a; cpu_out = ~d; cpu_we = ~we;
        if (clr_in_access) fault_clr = 1'b1;
        k = 0; got = 1'b0;
        while (k < 40 && !got) begin
            @(negedge clock);
            k++;
            fault_clr = 1'b0;
            if (cpu_ready) begin
                got = 1'b1;
                cpu_req = 1'b0;
            end else if (toggle) begin
                cpu_req = ~cpu_req;
            end
        end
        cpu_req = 1'b0;
        chk("ready_seen", {31'd0, got}, 32'd1);
        chk("latency", k, lat);
    endtask

    initial begin
        int r1, r2;
        reset_n = 1'b0; cpu_address = '0; cpu_out = '0; cpu_we = 1'b0; cpu_req = 1'b0;
        fault_clr = 1'b0;
        mem_q = {8'h77, 8'hC3, 8'h11, 8'h5A};
        repeat (3) @(posedge clock);
        @(negedge clock);
        chk("rst_cpu_in", {24'd0, cpu_in}, 32'hFF);
        chk("rst_ready", {31'd0, cpu_ready}, 32'd0);
        chk("rst_mem_we", {28'd0, mem_we}, 32'd0);
        chk("rst_fault", {31'd0, fault}, 32'd0);
        reset_n = 1'b1;

        access(20'h00010, 8'h00, 1'b0, 2, 8'h5A, 1'b0, 4'b0000, 1'b0, 1'b0);
        access(20'hA0123, 8'h3C, 1'b1, 3, 8'h11, 1'b0, 4'b0010, 1'b0, 1'b0);
        access(20'h50000, 8'h00, 1'b0, 2, 8'hFF, 1'b1, 4'b0000, 1'b0, 1'b0);
        @(negedge clock); fault_clr = 1'b1;
        @(negedge clock); fault_clr = 1'b0;
        chk("fault_cleared", {31'd0, fault}, 32'd0);
        access(20'h50000, 8'h00, 1'b0, 2, 8'hFF, 1'b1, 4'b0000, 1'b0, 1'b1);
        access(20'hFFFF0, 8'h00, 1'b0, 17, 8'hC3, 1'b1, 4'b0000, 1'b1, 1'b0);

        // back-to-back: req held high through the ready cycle
        rdy_q.push_back('{data: 8'h5A, flt: 1'b1});
        rdy_q.push_back('{data: 8'h5A, flt: 1'b1});
        @(negedge clock);
        cpu_address = 20'h00020; cpu_we = 1'b0; cpu_req = 1'b1;
        @(posedge clock);
        r1 = -1; r2 = -1;
        for (int k = 0; k < 12; k++) begin
            @(negedge clock);
            if (k == 3) cpu_req = 1'b0;
            if (cpu_ready) begin
                if (r1 < 0) r1 = k; else r2 = k;
            end
        end
        chk("b2b_first", r1, 2);
        chk("b2b_second", r2, 5);

        access(20'h01000, 8'h96, 1'b1, 2, 8'h5A, 1'b1, 4'b0001, 1'b0, 1'b0);

        // reset in the middle of a long wait
        @(negedge clock);
        cpu_address = 20'hFFFF0; cpu_we = 1'b1; cpu_out = 8'hAA; cpu_req = 1'b1;
        @(posedge clock);
        @(negedge clock); cpu_req = 1'b0;
        repeat (4) @(negedge clock);
        reset_n = 1'b0;
        @(posedge clock);
        @(negedge clock);
        chk("midrst_cpu_in", {24'd0, cpu_in}, 32'hFF);
        chk("midrst_ready", {31'd0, cpu_ready}, 32'd0);
        chk("midrst_fault", {31'd0, fault}, 32'd0);
        chk("midrst_mem_address", {12'd0, mem_address}, 32'd0);
        reset_n = 1'b1;
        repeat (20) @(negedge clock);

        access(20'h00010, 8'h00, 1'b0, 2, 8'h5A, 1'b0, 4'b0000, 1'b0, 1'b0);
        access(20'h50000, 8'h42, 1'b1, 2, 8'hFF, 1'b1, 4'b0000, 1'b0, 1'b0);

        repeat (4) @(negedge clock);
        chk("ready_queue_empty", rdy_q.size(), 0);
        chk("strobe_queue_empty", stb_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
